sample_deserializer: RTL

- Upstream neighbour of the connect stage in the SERDES datapath.
- Accepts one BIT_WIDTH sample per val/rdy handshake and assembles N_SAMPLES consecutive samples into one flattened frame.
- Presents the frame on a val/rdy output that feeds the connect stage's parallel recv_msg.
- Sustains one sample per cycle, with no bubble between frames, when downstream is always ready.

---
 rtl/sample_deser_pkg.sv | 14 +
 rtl/sample_deserializer_if.sv | 31 +++
 rtl/sample_deser_ctrl.sv | 69 ++++++
 rtl/sample_deserializer.sv | 53 +++++
 4 files changed

// File: rtl/sample_deser_pkg.sv
// Shared types and helpers for the sample deserializer.
// Imported by the control FSM and the top-level bank.
package sample_deser_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } state_e;

    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sample_deserializer_if.sv
// Sample-in / frame-out val/rdy bundle for the deserializer.
// slave is the deserializer view, master the environment view.
interface sample_deserializer_if #(
    parameter int BIT_WIDTH = 32,
    parameter int N_SAMPLES = 8
);
    logic [BIT_WIDTH-1:0]           recv_msg;
    logic                           recv_val;
    logic                           recv_rdy;
    logic [BIT_WIDTH*N_SAMPLES-1:0] send_msg;
    logic                           send_val;
    logic                           send_rdy;

    modport slave (
        input  recv_msg,
        input  recv_val,
        output recv_rdy,
        output send_msg,
        output send_val,
        input  send_rdy
    );

    modport master (
        output recv_msg,
        output recv_val,
        input  recv_rdy,
        input  send_msg,
        input  send_val,
        output send_rdy
    );
endinterface

// File: rtl/sample_deser_ctrl.sv
// COLLECT/FULL control and sample index for the deserializer.
// Emits the bank write strobe and index; send_val is registered.
module sample_deser_ctrl
    import sample_deser_pkg::*;
#(
    parameter  int N_SAMPLES = 8,
    localparam int IW        = idx_width(N_SAMPLES)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          recv_val,
    input  logic          send_rdy,
    output logic          recv_rdy,
    output logic          send_val,
    output logic          wr_en,
    output logic [IW-1:0] wr_idx
);

    localparam logic [IW-1:0] LAST = IW'(N_SAMPLES - 1);
    localparam logic [IW-1:0] ONE  = (N_SAMPLES > 1) ? IW'(1) : '0;

    state_e        state;
    logic [IW-1:0] idx;
    logic          recv_fire;
    logic          send_fire;

    // In FULL, a sample may only enter on the cycle the frame leaves.
    assign recv_rdy  = (state == COLLECT) | send_rdy;
    assign recv_fire = recv_val & recv_rdy;
    assign send_fire = send_val & send_rdy;
    assign wr_en     = recv_fire;
    assign wr_idx    = idx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= COLLECT;
            idx      <= '0;
            send_val <= 1'b0;
        end else begin
            unique case (state)
                COLLECT: begin
                    if (recv_fire) begin
                        if (idx == LAST) begin
                            idx      <= '0;
                            state    <= FULL;
                            send_val <= 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                FULL: begin
                    // Single-sample frames chain straight back into FULL.
                    if (send_fire && !(recv_fire && N_SAMPLES == 1)) begin
                        state    <= COLLECT;
                        send_val <= 1'b0;
                        idx      <= recv_fire ? ONE : '0;
                    end
                end
                default: begin
                    state    <= COLLECT;
                    idx      <= '0;
                    send_val <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/sample_deserializer.sv
// Assembles N_SAMPLES val/rdy samples into one flattened frame.
// Sample i of the frame lands at send_msg[BIT_WIDTH*i +: BIT_WIDTH].
module sample_deserializer
    import sample_deser_pkg::*;
#(
    parameter int BIT_WIDTH = 32,
    parameter int N_SAMPLES = 8
) (
    input logic                  clk,
    input logic                  reset,
    sample_deserializer_if.slave bus
);

    localparam int IW = idx_width(N_SAMPLES);

    logic [BIT_WIDTH-1:0] bank [N_SAMPLES];
    logic                 wr_en;
    logic [IW-1:0]        wr_idx;
    logic                 recv_rdy;
    logic                 send_val;

    sample_deser_ctrl #(
        .N_SAMPLES (N_SAMPLES)
    ) u_ctrl (
        .clk      (clk),
        .reset    (reset),
        .recv_val (bus.recv_val),
        .send_rdy (bus.send_rdy),
        .recv_rdy (recv_rdy),
        .send_val (send_val),
        .wr_en    (wr_en),
        .wr_idx   (wr_idx)
    );

    assign bus.recv_rdy = recv_rdy;
    assign bus.send_val = send_val;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_SAMPLES; i++) begin
                bank[i] <= '0;
            end
        end else if (wr_en) begin
            bank[wr_idx] <= bus.recv_msg;
        end
    end

    // The bank is the output; downstream ignores it while send_val is low.
    for (genvar i = 0; i < N_SAMPLES; i++) begin : g_flat
        assign bus.send_msg[i*BIT_WIDTH +: BIT_WIDTH] = bank[i];
    end

endmodule
